ahb_protocol_checker: RTL and testbench

AHB_PROTOCOL_CHECKER -- requirements
Module: ahb_protocol_checker

---
 rtl/ahb_chk_pkg.sv | 56 +++++
 rtl/ahb_burst_addr_calc.sv | 23 ++
 rtl/ahb_protocol_checker.sv | 152 +++++++++++++++
 tb/tb_ahb_protocol_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_chk_pkg.sv
// Shared AHB encodings, checker FSM states and burst helper functions.
// Stateless definitions only; no latency or backpressure of its own.
package ahb_chk_pkg;

    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'd0, BU_INCR  = 3'd1, BU_WRAP4  = 3'd2, BU_INCR4  = 3'd3,
        BU_WRAP8  = 3'd4, BU_INCR8 = 3'd5, BU_WRAP16 = 3'd6, BU_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {RS_OKAY = 2'b00, RS_ERROR = 2'b01, RS_RETRY = 2'b10, RS_SPLIT = 2'b11} hresp_e;

    typedef enum logic [2:0] {
        CHK_ALIGN = 3'd0, CHK_SIZE = 3'd1, CHK_KB = 3'd2, CHK_SEQADDR = 3'd3,
        CHK_SEQCTL = 3'd4, CHK_BEATS = 3'd5, CHK_RESP2 = 3'd6, CHK_IDLE_OK = 3'd7
    } chk_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} bst_e;
    typedef enum logic {RSP_OK = 1'b0, RSP_FIRST = 1'b1} rsp_e;

    // Zero means undefined length (INCR).
    function automatic logic [4:0] beat_len(input logic [2:0] burst);
        case (burst)
            BU_SINGLE:           return 5'd1;
            BU_INCR:             return 5'd0;
            BU_WRAP4, BU_INCR4:  return 5'd4;
            BU_WRAP8, BU_INCR8:  return 5'd8;
            default:             return 5'd16;
        endcase
    endfunction

    // Byte-address bits that wrap inside the burst boundary; zero for non-wrapping bursts.
    function automatic logic [11:0] wrap_mask(input logic [2:0] burst, input logic [2:0] size);
        case (burst)
            BU_WRAP4:  return (12'd4 << size) - 12'd1;
            BU_WRAP8:  return (12'd8 << size) - 12'd1;
            BU_WRAP16: return (12'd16 << size) - 12'd1;
            default:   return 12'd0;
        endcase
    endfunction

    function automatic logic [6:0] align_mask(input logic [2:0] size);
        return (7'd1 << size) - 7'd1;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// Next beat address for INCR/WRAP bursts from the current address, HSIZE and HBURST.
// Purely combinational, zero latency; no flow control.
module ahb_burst_addr_calc
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [2:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        incr      = addr + (ADDR_W'(1) << size);
        mask      = ADDR_W'(wrap_mask(burst, size));
        next_addr = (mask == '0) ? incr : ((addr & ~mask) | (incr & mask));
    end

endmodule

// File: rtl/ahb_protocol_checker.sv
// Passive AHB monitor: burst/response FSMs feed eight checks into sticky flags, first-capture and a counter.
// Violations appear on viol_pulse_o one cycle after the offending sample; never stalls the bus.
module ahb_protocol_checker
    import ahb_chk_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         CNT_W  = 16,
    parameter logic [7:0] CHK_EN = 8'hFF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HBURST,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic              clr_i,
    output logic [7:0]        viol_pulse_o,
    output logic [7:0]        viol_sticky_o,
    output logic [2:0]        first_code_o,
    output logic [ADDR_W-1:0] first_addr_o,
    output logic [CNT_W-1:0]  viol_cnt_o,
    output logic              irq_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    bst_e              bst_q, bst_d;
    rsp_e              rsp_q, rsp_d;
    hresp_e            resp_lat;
    htrans_e           dph_trans;
    logic [2:0]        lat_burst, lat_size;
    logic              lat_write;
    logic [3:0]        beat_cnt;
    logic [4:0]        len;
    logic [ADDR_W-1:0] exp_addr, next_addr;
    logic              err_q, err_d, done_q, done_d;
    logic              acc_ns, acc_seq, acc_idle, acc_busy, resp_bad, exempt, is_fixed, final_beat;
    logic [7:0]        chk, pulse_d;

    ahb_burst_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
        .addr      (HADDR),
        .size      (HSIZE),
        .burst     (HBURST),
        .next_addr (next_addr)
    );

    always_comb begin
        acc_ns     = HREADY && (HTRANS == TR_NONSEQ);
        acc_seq    = HREADY && (HTRANS == TR_SEQ);
        acc_idle   = HREADY && (HTRANS == TR_IDLE);
        acc_busy   = HREADY && (HTRANS == TR_BUSY);
        resp_bad   = (HRESP != RS_OKAY);
        exempt     = err_q || resp_bad;
        len        = beat_len(lat_burst);
        is_fixed   = (lat_burst != BU_INCR);
        final_beat = acc_seq && (bst_q == ST_BURST) && is_fixed && ({1'b0, beat_cnt} == len - 5'd1);

        bst_d = bst_q;
        if (acc_ns)                     bst_d = (HBURST != BU_SINGLE) ? ST_BURST : ST_IDLE;
        else if (acc_idle || final_beat) bst_d = ST_IDLE;

        // Error exemption lasts until the burst is closed by an IDLE or NONSEQ.
        err_d  = (acc_ns || acc_idle) ? 1'b0 : (err_q || resp_bad);
        done_d = final_beat ? 1'b1 : ((acc_ns || acc_idle) ? 1'b0 : done_q);

        chk              = '0;
        chk[CHK_ALIGN]   = (acc_ns || acc_seq) && (|(HADDR[6:0] & align_mask(HSIZE)));
        chk[CHK_SIZE]    = (acc_ns || acc_seq) && ((32'd8 << HSIZE) > 32'(DATA_W));
        chk[CHK_KB]      = acc_seq && (HADDR[9:0] == 10'd0);
        chk[CHK_SEQADDR] = acc_seq && (bst_q == ST_BURST) && (HADDR != exp_addr);
        chk[CHK_SEQCTL]  = (acc_seq || acc_busy) &&
                           ((bst_q == ST_IDLE) || (HBURST != lat_burst) || (HSIZE != lat_size) || (HWRITE != lat_write));
        chk[CHK_BEATS]   = !exempt && (((bst_q == ST_BURST) && is_fixed && (acc_ns || acc_idle)) || (acc_seq && done_q));
        chk[CHK_IDLE_OK] = resp_bad && ((dph_trans == TR_IDLE) || (dph_trans == TR_BUSY));

        rsp_d = rsp_q;
        case (rsp_q)
            RSP_OK: begin
                if (resp_bad) begin
                    if (HREADY) chk[CHK_RESP2] = 1'b1;
                    else        rsp_d = RSP_FIRST;
                end
            end
            default: begin
                if (!HREADY || (HRESP != resp_lat)) chk[CHK_RESP2] = 1'b1;
                if (HREADY || !resp_bad)            rsp_d = RSP_OK;
            end
        endcase

        pulse_d = chk & CHK_EN;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bst_q         <= ST_IDLE;
            rsp_q         <= RSP_OK;
            resp_lat      <= RS_OKAY;
            dph_trans     <= TR_IDLE;
            lat_burst     <= '0;
            lat_size      <= '0;
            lat_write     <= 1'b0;
            beat_cnt      <= '0;
            exp_addr      <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            viol_pulse_o  <= '0;
            viol_sticky_o <= '0;
            first_code_o  <= '0;
            first_addr_o  <= '0;
            viol_cnt_o    <= '0;
        end else begin
            bst_q  <= bst_d;
            rsp_q  <= rsp_d;
            err_q  <= err_d;
            done_q <= done_d;
            if (resp_bad && !HREADY) resp_lat  <= hresp_e'(HRESP);
            if (HREADY)              dph_trans <= htrans_e'(HTRANS);
            if (acc_ns) begin
                lat_burst <= HBURST;
                lat_size  <= HSIZE;
                lat_write <= HWRITE;
                beat_cnt  <= 4'd1;
                exp_addr  <= next_addr;
            end else if (acc_seq) begin
                beat_cnt <= beat_cnt + 4'd1;
                exp_addr <= next_addr;
            end

            viol_pulse_o <= pulse_d;
            if (clr_i) begin
                viol_sticky_o <= pulse_d;
                viol_cnt_o    <= (|pulse_d) ? CNT_ONE : '0;
                first_code_o  <= (|pulse_d) ? lowest_idx(pulse_d) : 3'd0;
                first_addr_o  <= (|pulse_d) ? HADDR : '0;
            end else begin
                viol_sticky_o <= viol_sticky_o | pulse_d;
                if ((|pulse_d) && (viol_cnt_o != {CNT_W{1'b1}})) viol_cnt_o <= viol_cnt_o + CNT_ONE;
                if ((|pulse_d) && (viol_sticky_o == 8'h00)) begin
                    first_code_o <= lowest_idx(pulse_d);
                    first_addr_o <= HADDR;
                end
            end
        end
    end

    assign irq_o = |viol_sticky_o;

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Directed-vector bench for ahb_protocol_checker with hand-computed expected flags.
module tb_ahb_protocol_checker;
    import ahb_chk_pkg::*;

    logic        HCLK;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        clr_i;
    logic [7:0]  viol_pulse_o;
    logic [7:0]  viol_sticky_o;
    logic [2:0]  first_code_o;
    logic [31:0] first_addr_o;
    logic [15:0] viol_cnt_o;
    logic        irq_o;

    int n_total = 0;
    int n_pass  = 0;

    ahb_protocol_checker dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HTRANS        (HTRANS),
        .HBURST        (HBURST),
        .HSIZE         (HSIZE),
        .HWRITE        (HWRITE),
        .HADDR         (HADDR),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .clr_i         (clr_i),
        .viol_pulse_o  (viol_pulse_o),
        .viol_sticky_o (viol_sticky_o),
        .first_code_o  (first_code_o),
        .first_addr_o  (first_addr_o),
        .viol_cnt_o    (viol_cnt_o),
        .irq_o         (irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Drive one bus cycle, then sit 1ns past the edge that sampled it.
    task automatic step(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                        input logic [31:0] ad, input logic rdy, input logic [1:0] rs);
        HTRANS = tr; HBURST = bu; HSIZE = sz; HADDR = ad; HREADY = rdy; HRESP = rs;
        @(posedge HCLK);
        #1;
    endtask

    task automatic beat(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] ad);
        step(tr, bu, 3'd2, ad, 1'b1, RS_OKAY);
    endtask

    task automatic idle_cycle();
        step(TR_IDLE, BU_SINGLE, 3'd2, 32'h0, 1'b1, RS_OKAY);
    endtask

    task automatic clear();
        clr_i = 1'b1;
        idle_cycle();
        clr_i = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; clr_i = 1'b0; HWRITE = 1'b0;
        idle_cycle();
        idle_cycle();
        check("rst_pulse",  32'(viol_pulse_o),  32'h0);
        check("rst_sticky", 32'(viol_sticky_o), 32'h0);
        check("rst_cnt",    32'(viol_cnt_o),    32'h0);
        check("rst_code",   32'(first_code_o),  32'h0);
        check("rst_addr",   first_addr_o,       32'h0);
        check("rst_irq",    32'(irq_o),         32'h0);
        HRESET = 1'b0;
        idle_cycle();

        // WRAP4 word burst wrapping inside the 16-byte block.
        beat(TR_NONSEQ, BU_WRAP4, 32'h38); check("wrap_b0", 32'(viol_pulse_o), 32'h0);
        beat(TR_SEQ,    BU_WRAP4, 32'h3C); check("wrap_b1", 32'(viol_pulse_o), 32'h0);
        beat(TR_SEQ,    BU_WRAP4, 32'h30); check("wrap_b2", 32'(viol_pulse_o), 32'h0);
        beat(TR_SEQ,    BU_WRAP4, 32'h34); check("wrap_b3", 32'(viol_pulse_o), 32'h0);
        idle_cycle();
        check("wrap_sticky", 32'(viol_sticky_o), 32'h0);
        check("wrap_cnt",    32'(viol_cnt_o),    32'h0);

        // INCR4 crossing a 1KB boundary.
        beat(TR_NONSEQ, BU_INCR4, 32'h3F8);
        beat(TR_SEQ,    BU_INCR4, 32'h3FC);
        beat(TR_SEQ,    BU_INCR4, 32'h400); check("kb_pulse", 32'(viol_pulse_o), 32'h04);
        beat(TR_SEQ,    BU_INCR4, 32'h404);
        idle_cycle();
        check("kb_sticky", 32'(viol_sticky_o), 32'h04);
        check("kb_addr",   first_addr_o,       32'h400);
        check("kb_code",   32'(first_code_o),  32'h2);
        check("kb_cnt",    32'(viol_cnt_o),    32'h1);

        // INCR8 cut short by a NONSEQ after three beats.
        clear();
        beat(TR_NONSEQ, BU_INCR8, 32'h100);
        beat(TR_SEQ,    BU_INCR8, 32'h104);
        beat(TR_SEQ,    BU_INCR8, 32'h108); check("short_pre", 32'(viol_pulse_o), 32'h0);
        beat(TR_NONSEQ, BU_SINGLE, 32'h200); check("short_pulse", 32'(viol_pulse_o), 32'h20);
        check("short_cnt",  32'(viol_cnt_o),   32'h1);
        check("short_irq",  32'(irq_o),        32'h1);
        check("short_code", 32'(first_code_o), 32'h5);
        idle_cycle(); check("short_post", 32'(viol_pulse_o), 32'h0);

        // One-cycle ERROR, then IDLE abandons the INCR4 without a BEATS flag.
        clear();
        beat(TR_NONSEQ, BU_INCR4, 32'h100);
        step(TR_SEQ, BU_INCR4, 3'd2, 32'h104, 1'b1, RS_ERROR); check("err1_pulse", 32'(viol_pulse_o), 32'h40);
        idle_cycle(); check("err1_idle", 32'(viol_pulse_o), 32'h0);
        check("err1_sticky", 32'(viol_sticky_o), 32'h40);

        // Doubleword at 0x102 on a 32-bit bus: ALIGN and SIZE together.
        clear();
        step(TR_NONSEQ, BU_SINGLE, 3'd3, 32'h102, 1'b1, RS_OKAY);
        check("as_pulse", 32'(viol_pulse_o), 32'h03);
        check("as_code",  32'(first_code_o), 32'h0);
        check("as_addr",  first_addr_o,      32'h102);

        // Clear coinciding with a fresh ALIGN violation.
        clr_i = 1'b1;
        beat(TR_NONSEQ, BU_SINGLE, 32'h301);
        clr_i = 1'b0;
        check("clr_sticky", 32'(viol_sticky_o), 32'h01);
        check("clr_cnt",    32'(viol_cnt_o),    32'h1);
        check("clr_addr",   first_addr_o,       32'h301);
        check("clr_code",   32'(first_code_o),  32'h0);

        // Error responses to an IDLE data phase, then a mismatched two-cycle response.
        clear();
        step(TR_IDLE, BU_SINGLE, 3'd2, 32'h0, 1'b0, RS_ERROR); check("iok_c1", 32'(viol_pulse_o), 32'h80);
        step(TR_IDLE, BU_SINGLE, 3'd2, 32'h0, 1'b1, RS_ERROR); check("iok_c2", 32'(viol_pulse_o), 32'h80);
        beat(TR_NONSEQ, BU_SINGLE, 32'h10);                     check("r2_ns",  32'(viol_pulse_o), 32'h0);
        step(TR_IDLE, BU_SINGLE, 3'd2, 32'h0, 1'b0, RS_ERROR); check("r2_c1",  32'(viol_pulse_o), 32'h0);
        step(TR_IDLE, BU_SINGLE, 3'd2, 32'h0, 1'b1, RS_RETRY); check("r2_c2",  32'(viol_pulse_o), 32'h40);
        check("r2_sticky", 32'(viol_sticky_o), 32'hC0);

        // SEQ with no burst open, then a wrong SEQ address in an INCR.
        clear();
        beat(TR_SEQ, BU_INCR, 32'h20);     check("ctl_idle_seq", 32'(viol_pulse_o), 32'h10);
        beat(TR_NONSEQ, BU_INCR, 32'h40);
        beat(TR_SEQ, BU_INCR, 32'h48);     check("seqaddr",      32'(viol_pulse_o), 32'h08);
        idle_cycle();                      check("incr_end",     32'(viol_pulse_o), 32'h0);

        // SEQ past the end of an INCR4.
        clear();
        beat(TR_NONSEQ, BU_INCR4, 32'h0);
        beat(TR_SEQ, BU_INCR4, 32'h4);
        beat(TR_SEQ, BU_INCR4, 32'h8);
        beat(TR_SEQ, BU_INCR4, 32'hC);     check("over_last", 32'(viol_pulse_o), 32'h0);
        beat(TR_SEQ, BU_INCR4, 32'h10);    check("over_pulse", 32'(viol_pulse_o), 32'h30);

        // Reset in the middle of an INCR4 abandons it silently.
        beat(TR_NONSEQ, BU_INCR4, 32'h0);
        beat(TR_SEQ, BU_INCR4, 32'h4);
        HRESET = 1'b1;
        idle_cycle();
        check("mrst_sticky", 32'(viol_sticky_o), 32'h0);
        check("mrst_cnt",    32'(viol_cnt_o),    32'h0);
        HRESET = 1'b0;
        idle_cycle();                      check("mrst_idle", 32'(viol_pulse_o), 32'h0);
        beat(TR_SEQ, BU_INCR4, 32'h8);     check("mrst_seq",  32'(viol_pulse_o), 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
